// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRunning,
        StLap,
        StPaused
    } sw_state_e;

    localparam int unsigned DigitW            = 4;
    localparam int unsigned NumDigits         = 5;
    localparam int unsigned DefTickDiv        = 25_000_000;
    localparam int unsigned DefDebounceCycles = 250_000;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button commands, run/lap/pause FSM, 1 Hz prescaler,
// lap snapshot and live/frozen display mux for the BCD counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DefTickDiv,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_ss,
    input  logic              btn_lc,
    input  logic [DigitW-1:0] s0,
    input  logic [DigitW-1:0] s1,
    input  logic [DigitW-1:0] m0,
    input  logic [DigitW-1:0] m1,
    input  logic [DigitW-1:0] h,
    output logic              cnt_enable,
    output logic              cnt_reset,
    output logic [DigitW-1:0] d_s0,
    output logic [DigitW-1:0] d_s1,
    output logic [DigitW-1:0] d_m0,
    output logic [DigitW-1:0] d_m1,
    output logic [DigitW-1:0] d_h,
    output logic              running,
    output logic              lap_active
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
    localparam int unsigned SW = NumDigits * DigitW;

    logic ss_p, lc_p;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ss (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_ss),
        .press(ss_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_lc (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_lc),
        .press(lc_p)
    );

    sw_state_e      state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [SW-1:0]  snap_q, snap_d;
    logic [SW-1:0]  live;
    logic           cnt_enable_q, cnt_enable_d;
    logic           cnt_reset_q, cnt_reset_d;

    assign live       = {h, m1, m0, s1, s0};
    assign running    = (state_q == StRunning) || (state_q == StLap);
    assign lap_active = (state_q == StLap);

    // ss_p is tested first everywhere, so a simultaneous lc_p is dropped.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_reset_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (ss_p) state_d = StRunning;
            end
            StRunning: begin
                if (ss_p) begin
                    state_d = StPaused;
                end else if (lc_p) begin
                    state_d = StLap;
                    snap_d  = live;
                end
            end
            StLap: begin
                if (ss_p) begin
                    state_d = StPaused;
                end else if (lc_p) begin
                    state_d = StRunning;
                end
            end
            StPaused: begin
                if (ss_p) begin
                    state_d = StRunning;
                end else if (lc_p) begin
                    state_d     = StIdle;
                    cnt_reset_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh start counts a full period; a resume continues the held count.
    always_comb begin
        presc_d      = presc_q;
        cnt_enable_d = 1'b0;
        if (state_q == StIdle) begin
            if (ss_p) presc_d = '0;
        end else if (running) begin
            if (presc_q == PrescLast) begin
                presc_d      = '0;
                cnt_enable_d = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            snap_q       <= '0;
            cnt_enable_q <= 1'b0;
            cnt_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            snap_q       <= snap_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_reset_q  <= cnt_reset_d;
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_reset  = cnt_reset_q;

    assign {d_h, d_m1, d_m0, d_s1, d_s0} = lap_active ? snap_q : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_ss, btn_lc;
    logic [3:0] s0, s1, m0, m1, h;
    logic       cnt_enable, cnt_reset, running, lap_active;
    logic [3:0] d_s0, d_s1, d_m0, d_m1, d_h;

    stopwatch_ctrl #(
        .TICK_DIV       (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lc    (btn_lc),
        .s0        (s0),
        .s1        (s1),
        .m0        (m0),
        .m1        (m1),
        .h         (h),
        .cnt_enable(cnt_enable),
        .cnt_reset (cnt_reset),
        .d_s0      (d_s0),
        .d_s1      (d_s1),
        .d_m0      (d_m0),
        .d_m1      (d_m1),
        .d_h       (d_h),
        .running   (running),
        .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          run;
        bit          lap;
        bit          en;
        bit          rst;
        bit          dchk;
        logic [19:0] disp;
    } ev_t;

    ev_t exp_q[$];
    ev_t e_cur;
    int  total = 0;
    int  bad = 0;
    bit  mon_on = 1'b0;
    bit  prev_run = 1'b0;
    bit  prev_lap = 1'b0;

    logic [19:0] disp_w;
    assign disp_w = {d_h, d_m1, d_m0, d_s1, d_s0};

    // An event is any strobe, any clear, or any change of running/lap_active.
    always @(negedge clk) begin
        if (mon_on && (cnt_enable || cnt_reset || running != prev_run || lap_active != prev_lap)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got cyc=%0d run=%0b lap=%0b en=%0b rst=%0b disp=%05h, none expected",
                         cyc, running, lap_active, cnt_enable, cnt_reset, disp_w);
            end else begin
                e_cur = exp_q.pop_front();
                if (e_cur.cyc != cyc || e_cur.run != running || e_cur.lap != lap_active ||
                    e_cur.en != cnt_enable || e_cur.rst != cnt_reset ||
                    (e_cur.dchk && e_cur.disp != disp_w)) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d run=%0b lap=%0b en=%0b rst=%0b disp=%05h, want cyc=%0d run=%0b lap=%0b en=%0b rst=%0b disp=%05h(chk=%0b)",
                             cyc, running, lap_active, cnt_enable, cnt_reset, disp_w,
                             e_cur.cyc, e_cur.run, e_cur.lap, e_cur.en, e_cur.rst, e_cur.disp, e_cur.dchk);
                end
            end
        end
        prev_run = running;
        prev_lap = lap_active;
    end

    task automatic push(input int c, input bit r, input bit l, input bit en, input bit rs,
                        input bit dc, input logic [19:0] d);
        ev_t e;
        e.cyc = c; e.run = r; e.lap = l; e.en = en; e.rst = rs; e.dchk = dc; e.disp = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Press lands in the FSM 7 cycles after the call; returns 16 cycles after the call.
    task automatic press(input bit ss, input bit lc);
        btn_ss = ss;
        btn_lc = lc;
        step(6);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        step(10);
    endtask

    task automatic set_live(input logic [19:0] v);
        {h, m1, m0, s1, s0} = v;
    endtask

    initial begin
        int p, t0, s, x, y, w;
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        set_live(20'h00000);
        step(3);

        // Reset release: cnt_reset visible for this one cycle only.
        push(cyc, 0, 0, 0, 1, 1, 20'h00000);
        reset  = 1'b0;
        mon_on = 1'b1;
        wait_until(53);

        // 3-cycle glitch is shorter than the debounce window.
        btn_ss = 1'b1;
        step(3);
        btn_ss = 1'b0;
        step(12);

        // Start and three strobes.
        p  = cyc;
        t0 = p + 7;
        push(t0, 1, 0, 0, 0, 0, 20'h0);
        push(t0 + 10, 1, 0, 1, 0, 0, 20'h0);
        push(t0 + 20, 1, 0, 1, 0, 0, 20'h0);
        push(t0 + 30, 1, 0, 1, 0, 0, 20'h0);
        press(1, 0);

        // Pause after 4 active cycles, resume 20 later: next strobe 6 active cycles on.
        s = t0 + 30;
        x = s + 4;
        wait_until(s - 3);
        push(x, 0, 0, 0, 0, 0, 20'h0);
        press(1, 0);
        wait_until(x + 20);
        y = x + 27;
        push(y, 1, 0, 0, 0, 0, 20'h0);
        push(y + 6, 1, 0, 1, 0, 0, 20'h0);
        press(1, 0);

        // Lap: display frozen at 7/3/2 while live digits move on.
        wait_until(y + 10);
        set_live(20'h00237);
        push(y + 16, 1, 0, 1, 0, 0, 20'h0);
        push(y + 17, 1, 1, 0, 0, 1, 20'h00237);
        push(y + 26, 1, 1, 1, 0, 1, 20'h00237);
        press(0, 1);
        wait_until(y + 27);
        set_live(20'h00238);
        wait_until(y + 30);
        set_live(20'h00239);
        wait_until(y + 31);
        push(y + 36, 1, 1, 1, 0, 1, 20'h00237);
        push(y + 38, 1, 0, 0, 0, 1, 20'h00239);
        push(y + 46, 1, 0, 1, 0, 1, 20'h00239);
        press(0, 1);

        // Pause then clear.
        wait_until(y + 47);
        push(y + 54, 0, 0, 0, 0, 0, 20'h0);
        press(1, 0);
        wait_until(y + 63);
        push(y + 70, 0, 0, 0, 1, 1, 20'h00239);
        press(0, 1);

        // lap/clear in IDLE does nothing.
        wait_until(y + 79);
        press(0, 1);

        // Fresh start counts a full period even though the prescaler held 8.
        wait_until(y + 95);
        w = y + 102;
        push(w, 1, 0, 0, 0, 0, 20'h0);
        push(w + 10, 1, 0, 1, 0, 0, 20'h0);
        press(1, 0);

        // Both buttons together in RUNNING: start/stop wins.
        wait_until(y + 111);
        push(y + 118, 0, 0, 0, 0, 0, 20'h0);
        press(1, 1);

        // Resume with 6 held, lap, then reset mid-prescale with a press pending.
        wait_until(y + 127);
        set_live(20'h00045);
        push(y + 134, 1, 0, 0, 0, 0, 20'h0);
        push(y + 138, 1, 0, 1, 0, 0, 20'h0);
        press(1, 0);
        wait_until(y + 143);
        push(y + 148, 1, 0, 1, 0, 0, 20'h0);
        push(y + 150, 1, 1, 0, 0, 1, 20'h00045);
        push(y + 158, 1, 1, 1, 0, 1, 20'h00045);
        press(0, 1);
        wait_until(y + 159);
        set_live(20'h00046);
        wait_until(y + 160);
        btn_ss = 1'b1;
        wait_until(y + 163);
        push(y + 164, 0, 0, 0, 1, 1, 20'h00046);
        reset = 1'b1;
        wait_until(y + 164);
        reset  = 1'b0;
        btn_ss = 1'b0;
        wait_until(y + 215);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d outstanding, want 0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the stopwatch counter chain: turns two raw push-buttons into start/stop, lap and clear commands, generates the 1 Hz count-enable strobe from the pixel clock, and drives the counter chain's `enable` and `reset`. It also holds a lap snapshot of the five BCD digits, so the VGA renderer shows either live or frozen time. It sits between the board buttons and the counter chain / display path.

## Interface
- `TICK_DIV`, 25_000_000: clk cycles per count tick (1 s at 25 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 250_000: cycles a synchronized button level must stay stable before it is accepted; must be ≥ 1.
- `clk`  in  1  system/pixel clock, single clock domain.
- `reset`  in  1  synchronous, active-high.
- `btn_ss`  in  1  raw start/stop button, asynchronous, active-high.
- `btn_lc`  in  1  raw lap/clear button, asynchronous, active-high.
- `s0, s1, m0, m1, h`  in  4 each  live BCD digits from the counter chain.
- `cnt_enable`  out  1  one-cycle count strobe to the counter chain.
- `cnt_reset`  out  1  synchronous clear to the counter chain.
- `d_s0, d_s1, d_m0, d_m1, d_h`  out  4 each  digits for display (live or lap snapshot).
- `running`  out  1  high in RUNNING or LAP.
- `lap_active`  out  1  high in LAP (display frozen).

## Operation
- Each button: 2-FF synchronizer, then debouncer; a rising edge of the accepted level gives a one-cycle press pulse (`ss_p`, `lc_p`). Holding a button produces exactly one press.
- FSM states IDLE, RUNNING, LAP, PAUSED; reset state IDLE.
- IDLE: `ss_p` → RUNNING (prescaler cleared to 0). `lc_p` ignored.
- RUNNING: `ss_p` → PAUSED. `lc_p` → LAP, snapshot register loads `s0..h` on the same edge.
- LAP: `ss_p` → PAUSED (freeze released). `lc_p` → RUNNING (freeze released).
- PAUSED: `ss_p` → RUNNING (prescaler resumes from its held value). `lc_p` → IDLE and one-cycle `cnt_reset` pulse.
- Simultaneous `ss_p` and `lc_p` in the same cycle: `ss_p` wins, `lc_p` dropped.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING/LAP and holds otherwise. At terminal count it wraps to 0 and `cnt_enable` pulses. Counting continues during LAP.
- Display mux: `d_*` = snapshot when `lap_active`, else live `s0..h` (combinational pass-through).
- Reset values: state IDLE, prescaler 0, snapshot 0, `cnt_enable` 0, `cnt_reset` 1, `running` 0, `lap_active` 0, synchronizer/debouncer levels 0.
- Reset asserted mid-operation (any state, mid-debounce, mid-prescale) aborts everything; a press pending in a debouncer is discarded.

## Timing
- Press latency: raw edge → `ss_p`/`lc_p` after 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle. A glitch shorter than DEBOUNCE_CYCLES is rejected.
- State, `running`, `lap_active` and snapshot update on the clk edge where the press pulse is high; visible the next cycle.
- `cnt_enable` is registered. The first strobe after leaving IDLE comes TICK_DIV cycles after the state becomes RUNNING, then every TICK_DIV cycles. Strobe spacing across a pause/resume sums to TICK_DIV active cycles.
- `cnt_reset` is registered. It is high during reset and for the first cycle after reset deasserts, then low. The clear pulse is exactly 1 cycle, in the cycle the state becomes IDLE.
- `cnt_enable` is never high in the same cycle as `cnt_reset`.

## Structure
- Shared package `stopwatch_pkg`: FSM state enum (IDLE, RUNNING, LAP, PAUSED), digit width constant (4), digit count (5), default TICK_DIV/DEBOUNCE_CYCLES.
- Sub-module `btn_debounce`: synchronizer + stability counter + edge pulse; parameter DEBOUNCE_CYCLES; instantiated twice.
- Prescaler, FSM, snapshot register and display mux live in `stopwatch_ctrl`.

## Test plan
Bench runs with TICK_DIV=10, DEBOUNCE_CYCLES=4.
- Reset release: `cnt_reset`=1 for one cycle after release, then 0; `running`=0; no `cnt_enable` over 50 cycles.
- Start: `btn_ss` held 6 cycles → one `ss_p`; `running`=1; `cnt_enable` strobes at +10, +20, +30 cycles. A 3-cycle glitch on `btn_ss` causes no transition.
- Pause/resume: pause after 4 active prescale cycles, wait 20, resume → next strobe after exactly 6 more active cycles.
- Lap: live digits s0=7, s1=3, m0=2 when `btn_lc` is pressed → `d_*` hold 7/3/2 while live digits advance; `cnt_enable` keeps strobing; second `lc_p` → `d_*` follow live digits again.
- Clear: from PAUSED, `lc_p` → one-cycle `cnt_reset`, state IDLE; `lc_p` in IDLE or PAUSED does not start counting.
- Conflicts: `ss_p` and `lc_p` in the same cycle in RUNNING → PAUSED, no snapshot. Reset asserted in LAP mid-prescale → all outputs return to reset values next cycle.
